// File: rtl/redmule_tcdm_share_arbiter.sv
// Shares one MP-lane TCDM port between a wide streamer and a narrow core.
// Wide accesses issue lane by lane; responses reassemble into one beat.
module redmule_tcdm_share_arbiter #(
  parameter int unsigned MP          = 9,
  parameter int unsigned NARROW_LANE = 0,
  parameter int unsigned MAX_WIDE    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wide_req_i,
  input  logic [31:0]      wide_add_i,
  input  logic             wide_wen_i,
  input  logic [MP*4-1:0]  wide_be_i,
  input  logic [MP*32-1:0] wide_data_i,
  output logic             wide_gnt_o,
  output logic             wide_r_valid_o,
  output logic [MP*32-1:0] wide_r_data_o,
  input  logic             narrow_req_i,
  input  logic [31:0]      narrow_add_i,
  input  logic             narrow_wen_i,
  input  logic [3:0]       narrow_be_i,
  input  logic [31:0]      narrow_data_i,
  output logic             narrow_gnt_o,
  output logic             narrow_r_valid_o,
  output logic [31:0]      narrow_r_data_o,
  output logic [MP-1:0]    mem_req_o,
  output logic [MP*32-1:0] mem_add_o,
  output logic [MP-1:0]    mem_wen_o,
  output logic [MP*4-1:0]  mem_be_o,
  output logic [MP*32-1:0] mem_data_o,
  input  logic [MP-1:0]    mem_gnt_i,
  input  logic [MP-1:0]    mem_r_valid_i,
  input  logic [MP*32-1:0] mem_r_data_i
);

  localparam int unsigned LW = (MP > 1) ? $clog2(MP) : 1;
  localparam logic [LW-1:0] NL = LW'(NARROW_LANE);
  localparam logic [3:0] MAXW = 4'(MAX_WIDE);

  typedef enum logic [1:0] {IDLE, W_ISSUE, W_RESP} state_e;

  state_e             state_q, state_d;
  logic [MP-1:0]      granted_q, granted_d;
  logic [MP-1:0]      rcvd_q, rcvd_d;
  logic [MP-1:0]      pend_q, pend_d;
  logic [MP-1:0]      own_w_q, own_w_d;
  logic [MP*32-1:0]   buf_q, buf_d;
  logic [3:0]         starve_q, starve_d;
  logic               err_q, err_d;

  logic [MP-1:0]      rv_ok, rv_w, issue, base, gnt_now;
  logic               all_rcvd, wide_done, arb;
  logic               sel_n, sel_w, all_gnt, n_gnt;

  // Arbitration and lane issue mask; reset forces everything quiet.
  always_comb begin
    rv_ok     = mem_r_valid_i & pend_q;
    rv_w      = rv_ok & own_w_q;
    all_rcvd  = &(rcvd_q | rv_w);
    wide_done = rst_n && (state_q != IDLE) && all_rcvd;
    arb       = rst_n && ((state_q == IDLE) || wide_done);
    sel_n     = arb && narrow_req_i
                && (!wide_req_i || (starve_q == MAXW));
    sel_w     = arb && !sel_n && wide_req_i;
    issue     = '0;
    base      = '0;
    if (sel_w) begin
      issue = '1;
    end else if (rst_n && (state_q == W_ISSUE)) begin
      issue = ~granted_q;
      base  = granted_q;
    end
    gnt_now = issue & mem_gnt_i;
    all_gnt = &(base | gnt_now);
    n_gnt   = sel_n && mem_gnt_i[NL];
  end

  // Drive memory lanes, grants and reassembled responses.
  always_comb begin
    mem_req_o        = '0;
    mem_add_o        = '0;
    mem_wen_o        = '0;
    mem_be_o         = '0;
    mem_data_o       = '0;
    wide_gnt_o       = (issue != '0) && all_gnt;
    narrow_gnt_o     = n_gnt;
    wide_r_valid_o   = wide_done;
    wide_r_data_o    = '0;
    narrow_r_valid_o = rv_ok[NL] & ~own_w_q[NL];
    narrow_r_data_o  = '0;
    for (int unsigned i = 0; i < MP; i++) begin
      if (issue[i]) begin
        mem_req_o[i]          = 1'b1;
        mem_add_o[i*32 +: 32] = wide_add_i + 32'(4 * i);
        mem_wen_o[i]          = wide_wen_i;
        mem_be_o[i*4 +: 4]    = wide_be_i[i*4 +: 4];
        mem_data_o[i*32 +: 32] = wide_data_i[i*32 +: 32];
      end
      if (wide_done) begin
        wide_r_data_o[i*32 +: 32] = rv_w[i] ? mem_r_data_i[i*32 +: 32]
                                            : buf_q[i*32 +: 32];
      end
    end
    if (sel_n) begin
      mem_req_o[NL]                   = 1'b1;
      mem_add_o[NARROW_LANE*32 +: 32] = narrow_add_i;
      mem_wen_o[NL]                   = narrow_wen_i;
      mem_be_o[NARROW_LANE*4 +: 4]    = narrow_be_i;
      mem_data_o[NARROW_LANE*32 +: 32] = narrow_data_i;
    end
    if (narrow_r_valid_o) begin
      narrow_r_data_o = mem_r_data_i[NARROW_LANE*32 +: 32];
    end
  end

  // Next-state: lane tracking, buffering, FSM and starvation count.
  always_comb begin
    state_d   = state_q;
    granted_d = granted_q;
    rcvd_d    = rcvd_q | rv_w;
    pend_d    = (pend_q & ~rv_ok) | gnt_now;
    own_w_d   = own_w_q | gnt_now;
    buf_d     = buf_q;
    starve_d  = starve_q;
    err_d     = err_q | (|(mem_r_valid_i & ~pend_q));
    for (int unsigned i = 0; i < MP; i++) begin
      if (rv_w[i]) buf_d[i*32 +: 32] = mem_r_data_i[i*32 +: 32];
    end
    if (n_gnt) begin
      pend_d[NL]  = 1'b1;
      own_w_d[NL] = 1'b0;
      starve_d    = '0;
    end
    if (wide_done) begin
      rcvd_d    = '0;
      granted_d = '0;
      state_d   = IDLE;
    end
    if (issue != '0) begin
      if (all_gnt) begin
        granted_d = '0;
        state_d   = W_RESP;
        if (narrow_req_i && (starve_q != MAXW)) begin
          starve_d = starve_q + 4'd1;
        end
      end else begin
        granted_d = base | gnt_now;
        state_d   = W_ISSUE;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      granted_q <= '0;
      rcvd_q    <= '0;
      pend_q    <= '0;
      own_w_q   <= '0;
      buf_q     <= '0;
      starve_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      granted_q <= granted_d;
      rcvd_q    <= rcvd_d;
      pend_q    <= pend_d;
      own_w_q   <= own_w_d;
      buf_q     <= buf_d;
      starve_q  <= starve_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_redmule_tcdm_share_arbiter.sv
// Directed bench for the wide/narrow TCDM share arbiter.
// One-cycle memory model; vector table plus starvation and reset sequences.
module tb_redmule_tcdm_share_arbiter;

  localparam int MP = 9;
  localparam logic [31:0] MAGIC = 32'hA5A5_5A5A;
  localparam logic [31:0] NADD  = 32'h1c01_0010;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wide_req_i;
  logic [31:0]      wide_add_i;
  logic             wide_wen_i;
  logic [MP*4-1:0]  wide_be_i;
  logic [MP*32-1:0] wide_data_i;
  logic             wide_gnt_o;
  logic             wide_r_valid_o;
  logic [MP*32-1:0] wide_r_data_o;
  logic             narrow_req_i;
  logic [31:0]      narrow_add_i;
  logic             narrow_wen_i;
  logic [3:0]       narrow_be_i;
  logic [31:0]      narrow_data_i;
  logic             narrow_gnt_o;
  logic             narrow_r_valid_o;
  logic [31:0]      narrow_r_data_o;
  logic [MP-1:0]    mem_req_o;
  logic [MP*32-1:0] mem_add_o;
  logic [MP-1:0]    mem_wen_o;
  logic [MP*4-1:0]  mem_be_o;
  logic [MP*32-1:0] mem_data_o;
  logic [MP-1:0]    mem_gnt_i;
  logic [MP-1:0]    mem_r_valid_i;
  logic [MP*32-1:0] mem_r_data_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  redmule_tcdm_share_arbiter #(
    .MP(MP), .NARROW_LANE(0), .MAX_WIDE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wide_req_i(wide_req_i), .wide_add_i(wide_add_i),
    .wide_wen_i(wide_wen_i), .wide_be_i(wide_be_i),
    .wide_data_i(wide_data_i), .wide_gnt_o(wide_gnt_o),
    .wide_r_valid_o(wide_r_valid_o), .wide_r_data_o(wide_r_data_o),
    .narrow_req_i(narrow_req_i), .narrow_add_i(narrow_add_i),
    .narrow_wen_i(narrow_wen_i), .narrow_be_i(narrow_be_i),
    .narrow_data_i(narrow_data_i), .narrow_gnt_o(narrow_gnt_o),
    .narrow_r_valid_o(narrow_r_valid_o),
    .narrow_r_data_o(narrow_r_data_o),
    .mem_req_o(mem_req_o), .mem_add_o(mem_add_o),
    .mem_wen_o(mem_wen_o), .mem_be_o(mem_be_o),
    .mem_data_o(mem_data_o), .mem_gnt_i(mem_gnt_i),
    .mem_r_valid_i(mem_r_valid_i), .mem_r_data_i(mem_r_data_i)
  );

  // Memory: respond exactly one cycle after each granted lane request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r_valid_i <= '0;
      mem_r_data_i  <= '0;
    end else begin
      mem_r_valid_i <= mem_req_o & mem_gnt_i;
      for (int i = 0; i < MP; i++)
        mem_r_data_i[i*32 +: 32] <= mem_add_o[i*32 +: 32] ^ MAGIC;
    end
  end

  typedef struct {
    logic          nreq;
    logic          wreq;
    logic          wwen;
    logic [MP-1:0] gnt;
    logic [MP-1:0] ereq;
    logic          ewg;
    logic          eng;
    logic          ewrv;
    logic          enrv;
  } vec_t;

  function automatic vec_t mk(logic nreq, logic wreq, logic wwen,
                              logic [MP-1:0] gnt, logic [MP-1:0] ereq,
                              logic ewg, logic eng,
                              logic ewrv, logic enrv);
    vec_t v;
    v.nreq = nreq; v.wreq = wreq; v.wwen = wwen;
    v.gnt  = gnt;  v.ereq = ereq;
    v.ewg  = ewg;  v.eng  = eng;
    v.ewrv = ewrv; v.enrv = enrv;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [MP*32-1:0] act,
                     input logic [MP*32-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [MP*32-1:0] wide_exp_data(input logic [31:0] a);
    logic [MP*32-1:0] d;
    for (int i = 0; i < MP; i++)
      d[i*32 +: 32] = (a + 32'(4 * i)) ^ MAGIC;
    return d;
  endfunction

  function automatic logic [MP*32-1:0] wide_exp_add(input logic [31:0] a);
    logic [MP*32-1:0] d;
    for (int i = 0; i < MP; i++)
      d[i*32 +: 32] = a + 32'(4 * i);
    return d;
  endfunction

  vec_t tv[17];
  logic [31:0] wadd;

  initial begin
    rst_n         = 1'b0;
    wide_req_i    = 1'b0;
    wadd          = 32'h1000_0400;
    wide_add_i    = wadd;
    wide_wen_i    = 1'b1;
    wide_be_i     = '1;
    wide_data_i   = {MP{32'hDEAD_BEEF}};
    narrow_req_i  = 1'b0;
    narrow_add_i  = NADD;
    narrow_wen_i  = 1'b1;
    narrow_be_i   = 4'hF;
    narrow_data_i = 32'h1234_5678;
    mem_gnt_i     = '0;

    tv[0]  = mk(1'b1,1'b0,1'b1,9'h1FF,9'h001,1'b0,1'b1,1'b0,1'b0);
    tv[1]  = mk(1'b0,1'b0,1'b1,9'h1FF,9'h000,1'b0,1'b0,1'b0,1'b1);
    tv[2]  = mk(1'b0,1'b1,1'b1,9'h1FF,9'h1FF,1'b1,1'b0,1'b0,1'b0);
    tv[3]  = mk(1'b0,1'b0,1'b1,9'h1FF,9'h000,1'b0,1'b0,1'b1,1'b0);
    tv[4]  = mk(1'b0,1'b1,1'b0,9'h177,9'h1FF,1'b0,1'b0,1'b0,1'b0);
    tv[5]  = mk(1'b0,1'b1,1'b0,9'h000,9'h088,1'b0,1'b0,1'b0,1'b0);
    tv[6]  = mk(1'b0,1'b1,1'b0,9'h1FF,9'h088,1'b1,1'b0,1'b0,1'b0);
    tv[7]  = mk(1'b0,1'b0,1'b0,9'h1FF,9'h000,1'b0,1'b0,1'b1,1'b0);
    tv[8]  = mk(1'b0,1'b1,1'b1,9'h1FF,9'h1FF,1'b1,1'b0,1'b0,1'b0);
    tv[9]  = mk(1'b1,1'b0,1'b1,9'h1FF,9'h001,1'b0,1'b1,1'b1,1'b0);
    tv[10] = mk(1'b0,1'b0,1'b1,9'h1FF,9'h000,1'b0,1'b0,1'b0,1'b1);
    tv[11] = mk(1'b1,1'b1,1'b1,9'h1FF,9'h1FF,1'b1,1'b0,1'b0,1'b0);
    tv[12] = mk(1'b1,1'b0,1'b1,9'h1FF,9'h001,1'b0,1'b1,1'b1,1'b0);
    tv[13] = mk(1'b0,1'b0,1'b1,9'h1FF,9'h000,1'b0,1'b0,1'b0,1'b1);
    tv[14] = mk(1'b1,1'b0,1'b1,9'h000,9'h001,1'b0,1'b0,1'b0,1'b0);
    tv[15] = mk(1'b1,1'b0,1'b1,9'h001,9'h001,1'b0,1'b1,1'b0,1'b0);
    tv[16] = mk(1'b0,1'b0,1'b1,9'h1FF,9'h000,1'b0,1'b0,1'b0,1'b1);

    #2;
    chk("rst_mem_req", MP*32'(mem_req_o), '0);
    chk("rst_wide_rv", MP*32'(wide_r_valid_o), '0);
    chk("rst_narrow_rv", MP*32'(narrow_r_valid_o), '0);
    #10 rst_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      narrow_req_i = tv[k].nreq;
      wide_req_i   = tv[k].wreq;
      wide_wen_i   = tv[k].wwen;
      mem_gnt_i    = tv[k].gnt;
      #3;
      chk($sformatf("v%0d_mem_req", k), MP*32'(mem_req_o),
          MP*32'(tv[k].ereq));
      chk($sformatf("v%0d_wide_gnt", k), MP*32'(wide_gnt_o),
          MP*32'(tv[k].ewg));
      chk($sformatf("v%0d_narrow_gnt", k), MP*32'(narrow_gnt_o),
          MP*32'(tv[k].eng));
      chk($sformatf("v%0d_wide_rv", k), MP*32'(wide_r_valid_o),
          MP*32'(tv[k].ewrv));
      chk($sformatf("v%0d_narrow_rv", k), MP*32'(narrow_r_valid_o),
          MP*32'(tv[k].enrv));
      if (tv[k].ereq == 9'h1FF) begin
        chk($sformatf("v%0d_lane_add", k), mem_add_o, wide_exp_add(wadd));
        chk($sformatf("v%0d_lane_wen", k), MP*32'(mem_wen_o),
            MP*32'({MP{tv[k].wwen}}));
      end
      if (tv[k].ereq == 9'h001)
        chk($sformatf("v%0d_narrow_add", k), MP*32'(mem_add_o[31:0]),
            MP*32'(NADD));
      if (tv[k].ewrv)
        chk($sformatf("v%0d_wide_data", k), wide_r_data_o,
            wide_exp_data(wadd));
      if (tv[k].enrv)
        chk($sformatf("v%0d_narrow_data", k), MP*32'(narrow_r_data_o),
            MP*32'(NADD ^ MAGIC));
    end

    // Both requesters always active: four wide grants, then one narrow.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      narrow_req_i = 1'b1;
      wide_req_i   = 1'b1;
      wide_wen_i   = 1'b1;
      mem_gnt_i    = '1;
      #3;
      chk($sformatf("st%0d_wide_gnt", c), MP*32'(wide_gnt_o),
          MP*32'(c % 5 != 4));
      chk($sformatf("st%0d_narrow_gnt", c), MP*32'(narrow_gnt_o),
          MP*32'(c % 5 == 4));
      chk($sformatf("st%0d_wide_rv", c), MP*32'(wide_r_valid_o),
          MP*32'(c % 5 != 0));
      chk($sformatf("st%0d_narrow_rv", c), MP*32'(narrow_r_valid_o),
          MP*32'(c == 5));
      if (c % 5 == 4)
        chk($sformatf("st%0d_starve", c), MP*32'(dut.starve_q),
            MP*32'(4));
    end
    @(posedge clk); #1;
    narrow_req_i = 1'b0;
    wide_req_i   = 1'b0;
    #3;
    chk("st_drain_narrow_rv", MP*32'(narrow_r_valid_o), MP*32'(1));
    chk("st_drain_narrow_data", MP*32'(narrow_r_data_o),
        MP*32'(NADD ^ MAGIC));
    chk("st_drain_starve", MP*32'(dut.starve_q), '0);

    // Reset while 5 of 9 lanes hold a grant.
    @(posedge clk); #1;
    wide_req_i = 1'b1;
    mem_gnt_i  = 9'h01F;
    #3;
    chk("rs_issue_req", MP*32'(mem_req_o), MP*32'(9'h1FF));
    @(posedge clk); #1;
    chk("rs_pending_req", MP*32'(mem_req_o), MP*32'(9'h1E0));
    rst_n = 1'b0;
    #1;
    chk("rs_mem_req", MP*32'(mem_req_o), '0);
    chk("rs_mem_add", mem_add_o, '0);
    chk("rs_wide_gnt", MP*32'(wide_gnt_o), '0);
    chk("rs_narrow_gnt", MP*32'(narrow_gnt_o), '0);
    chk("rs_wide_rv", MP*32'(wide_r_valid_o), '0);
    chk("rs_narrow_rv", MP*32'(narrow_r_valid_o), '0);
    wide_req_i = 1'b0;
    mem_gnt_i  = '1;
    #3 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #4;
      chk($sformatf("rs_idle%0d_wide_rv", c), MP*32'(wide_r_valid_o), '0);
      chk($sformatf("rs_idle%0d_req", c), MP*32'(mem_req_o), '0);
    end
    @(posedge clk); #1;
    wadd       = 32'h1000_2000;
    wide_add_i = wadd;
    wide_req_i = 1'b1;
    #3;
    chk("rs_new_gnt", MP*32'(wide_gnt_o), MP*32'(1));
    chk("rs_new_add", mem_add_o, wide_exp_add(wadd));
    @(posedge clk); #1;
    wide_req_i = 1'b0;
    #3;
    chk("rs_new_rv", MP*32'(wide_r_valid_o), MP*32'(1));
    chk("rs_new_data", wide_r_data_o, wide_exp_data(wadd));
    @(posedge clk); #4;
    chk("rs_after_rv", MP*32'(wide_r_valid_o), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/redmule_tcdm_share_arbiter.md
Name: redmule_tcdm_share_arbiter

Overview:
- Shares one MP-lane, 32-bit-per-lane TCDM memory port set between two requesters.
- Wide requester: RedMulE streamer, DW = MP*32 bits, all lanes at once. Narrow requester: core data port, 32 bits, single lane.
- Issues wide accesses lane by lane with partial-grant tracking, reassembles per-lane responses, and guarantees narrow forward progress with a starvation counter.
- Sits between the RedMulE complex TCDM outputs and the bank memory.

Parameters:
MP, 9, number of 32-bit lanes; wide data width is MP*32.
NARROW_LANE, 0, lane index used for all narrow accesses; must be < MP.
MAX_WIDE, 4, consecutive wide grants allowed while narrow is pending; range 1..15.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wide_req_i  in  1  wide request; held stable until wide_gnt_o
wide_add_i  in  32  wide byte address; lane i uses wide_add_i + 4*i
wide_wen_i  in  1  1 = read, 0 = write
wide_be_i  in  MP*4  byte enables; lane i uses bits [4i+3:4i]
wide_data_i  in  MP*32  write data
wide_gnt_o  out  1  single-cycle pulse when the last pending lane is granted
wide_r_valid_o  out  1  single-cycle pulse when all MP lane responses are collected
wide_r_data_o  out  MP*32  assembled response; valid with wide_r_valid_o
narrow_req_i  in  1  narrow request; held until narrow_gnt_o
narrow_add_i  in  32  byte address
narrow_wen_i  in  1  1 = read, 0 = write
narrow_be_i  in  4  byte enables
narrow_data_i  in  32  write data
narrow_gnt_o  out  1  narrow grant (combinational from mem_gnt_i[NARROW_LANE])
narrow_r_valid_o  out  1  narrow response valid
narrow_r_data_o  out  32  narrow response data
mem_req_o  out  MP  per-lane request
mem_add_o  out  MP*32  per-lane address
mem_wen_o  out  MP  per-lane write-enable (active low)
mem_be_o  out  MP*4  per-lane byte enables
mem_data_o  out  MP*32  per-lane write data
mem_gnt_i  in  MP  per-lane grant
mem_r_valid_i  in  MP  per-lane response, exactly 1 cycle after grant, for reads and writes
mem_r_data_i  in  MP*32  per-lane response data

Behaviour:
- Reset (async, rst_n=0): state IDLE; lane masks cleared; starvation counter 0; owner flags cleared; all outputs 0.
- States:
  - IDLE: no wide transaction in flight.
  - W_ISSUE: wide lanes still awaiting grant.
  - W_RESP: all lanes granted; responses still outstanding.
- Arbitration in IDLE:
  - Narrow is selected if narrow_req_i && (!wide_req_i || starve_cnt == MAX_WIDE).
  - Otherwise wide is selected if wide_req_i.
  - Narrow drives only lane NARROW_LANE: mem_req_o = narrow_req_i, with narrow address, wen, be and data.
- Wide issue:
  - Entering from IDLE, all MP lanes drive mem_req_o with lane address, be and data.
  - Lanes with mem_gnt_i=1 set granted_q[i] and drop req from the next cycle. Remaining lanes keep req until granted.
  - wide_gnt_o pulses in the cycle where (granted_q | mem_gnt_i) becomes all-ones; that cycle moves to W_RESP, or to IDLE if all responses have already been collected.
  - If every lane is granted in the first cycle: wide_gnt_o in that same cycle, and W_ISSUE is skipped.
- Starvation counter:
  - Increments, saturating at MAX_WIDE, on each wide_gnt_o pulse while narrow_req_i=1.
  - Clears on narrow_gnt_o.
  - Holds otherwise.
- Responses:
  - Each lane has owner_q (wide or narrow) and pend_q, set on grant.
  - On mem_r_valid_i[i] with owner wide: mem_r_data_i[i] is stored into lane buffer i and rcvd_q[i] is set.
  - wide_r_valid_o pulses, with the buffered data (current-cycle data bypassed for the last lane), when rcvd covers all MP lanes. rcvd_q then clears and the state returns to IDLE.
  - Narrow responses are combinational pass-through: narrow_r_valid_o = mem_r_valid_i[NARROW_LANE] && owner narrow; data passes directly.
- Back-to-back:
  - A new wide or narrow request may be arbitrated in the same cycle wide_r_valid_o fires (IDLE next-state is evaluated combinationally).
  - A narrow response and a new wide issue on the same lane in the same cycle are legal; the owner flag updates after the response is routed.
- Only one wide transaction is outstanding at a time. Narrow is never issued outside IDLE.
- mem_r_valid_i on a lane without pend_q is ignored; a sticky flag err_q is available for assertions.
- Reset mid-operation discards partial grants and buffered data; no response is emitted afterwards.

Test Plan:
- Narrow-only read, address 0x1c010010, memory grants at once -> narrow_gnt_o cycle 0, narrow_r_valid_o cycle 1 with data; mem_req_o only on lane 0.
- Wide read, all lanes granted in cycle 0 -> wide_gnt_o cycle 0; wide_r_valid_o cycle 1; lane i address = base + 4i; 288-bit data assembled in lane order.
- Wide write with lanes 3 and 7 stalled for 2 cycles -> lanes 3 and 7 hold req for 2 extra cycles, other lanes drop req after cycle 0; wide_gnt_o in cycle 2; wide_r_valid_o in cycle 3.
- Both requesters continuously active, MAX_WIDE=4 -> 4 wide grants, then 1 narrow grant, repeating; starve_cnt reaches 4, then clears.
- Simultaneous events: last wide response and a new narrow request in the same cycle -> wide_r_valid_o and narrow issue in the same cycle, with correct routing on the next response.
- rst_n asserted while 5 of 9 lanes are granted -> all outputs 0 immediately; after release, a new wide request completes normally with no stale wide_r_valid_o.
